// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data ports via IDLE/ACC/RESP FSM; define ARB_RR_EN for round-robin.
// Latency: grant 1 cycle after request, ACC until ramready or TIMEOUT, then one RESP cycle with wait low.
// Backpressure: iwait/dwait stay high while the port requests, except in the RESP cycle of its own access.
module mem_arbiter #(
    parameter int          TIMEOUT = 64,
    parameter logic [31:0] TO_DATA = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready,
    output logic        err
);
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   iload_q, iload_d;
    logic [31:0]   dload_q, dload_d;
    logic          err_q, err_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   store_q, store_d;

    logic          d_req;
    logic          grant;
    logic          in_acc;
    logic [31:0]   sel_addr;
    logic          acc_ren;
    logic          acc_wen;

    always_comb begin
        d_req    = dREN | dWEN;
        in_acc   = (state_q == ACC);
        sel_addr = (owner_q == OWN_D) ? daddr : iaddr;
        // dREN together with dWEN is a write, so the read strobe is masked.
        acc_ren  = (owner_q == OWN_D) ? (dREN & ~dWEN) : iREN;
        acc_wen  = (owner_q == OWN_D) & dWEN;
`ifdef ARB_RR_EN
        grant    = (d_req & iREN) ? ~last_q : d_req;
`else
        grant    = d_req;
`endif
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        iload_d = iload_q;
        dload_d = dload_q;
        err_d   = err_q;
        addr_d  = addr_q;
        store_d = store_q;
        case (state_q)
            IDLE: begin
                if (d_req | iREN) begin
                    owner_d = grant;
                    last_d  = grant;
                    state_d = ACC;
                end
            end
            ACC: begin
                cnt_d   = cnt_q + CW'(1);
                addr_d  = sel_addr;
                store_d = dstore;
                if (ramready) begin
                    if (owner_q == OWN_I) begin
                        iload_d = ramload;
                    end else if (!dWEN) begin
                        dload_d = ramload;
                    end
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    if (owner_q == OWN_I) begin
                        iload_d = TO_DATA;
                    end else begin
                        dload_d = TO_DATA;
                    end
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_I;
            cnt_q   <= '0;
            iload_q <= '0;
            dload_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            store_q <= store_d;
        end
    end

    // Strobes derive from the async-reset state, so they fall the moment nRST asserts.
    assign ramREN   = in_acc & acc_ren;
    assign ramWEN   = in_acc & acc_wen;
    assign ramaddr  = in_acc ? sel_addr : addr_q;
    assign ramstore = in_acc ? dstore : store_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign err      = err_q;
    assign iwait    = iREN & ~((state_q == RESP) & (owner_q == OWN_I));
    assign dwait    = d_req & ~((state_q == RESP) & (owner_q == OWN_D));
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each access is laid out as a timeline (request, ACC cycles, RESP) and checked every cycle.
module tb_mem_arbiter;
    localparam int TO = 8;
    localparam logic [31:0] TOD = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ramready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN, err;

    mem_arbiter #(.TIMEOUT(TO), .TO_DATA(TOD)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready), .err(err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Model state and per-cycle expectations
    logic [31:0] m_iload, m_dload;
    logic        m_err, m_last;
    logic        chk_en;
    logic        exp_iwait, exp_dwait, exp_ren, exp_wen, exp_acc, exp_wrchk;
    logic [31:0] exp_addr, exp_store;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, expv);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("iwait", {31'd0, iwait}, {31'd0, exp_iwait});
            chk("dwait", {31'd0, dwait}, {31'd0, exp_dwait});
            chk("ramREN", {31'd0, ramREN}, {31'd0, exp_ren});
            chk("ramWEN", {31'd0, ramWEN}, {31'd0, exp_wen});
            chk("iload", iload, m_iload);
            chk("dload", dload, m_dload);
            chk("err", {31'd0, err}, {31'd0, m_err});
            if (exp_acc) chk("ramaddr", ramaddr, exp_addr);
            if (exp_wrchk) chk("ramstore", ramstore, exp_store);
        end
    end

    task automatic idle(input int n, input logic rdy);
        for (int c = 0; c < n; c++) begin
            iREN = 0; dREN = 0; dWEN = 0;
            ramready = rdy; ramload = 32'h7777_7777;
            exp_iwait = 0; exp_dwait = 0; exp_ren = 0; exp_wen = 0;
            exp_acc = 0; exp_wrchk = 0;
            @(posedge CLK); #1;
        end
    endtask

    // lat = ACC cycle (1-based) on which ramready is given; 0 or > TO means never.
    task automatic access(input logic ir, input logic dr, input logic dw,
                          input logic [31:0] ia, input logic [31:0] da,
                          input logic [31:0] ds, input logic [31:0] rl, input int lat);
        logic own_d, timed, in_acc, in_resp;
        int   nacc;
`ifdef ARB_RR_EN
        if (ir && (dr || dw)) own_d = !m_last;
        else                  own_d = dr || dw;
`else
        own_d = dr || dw;
`endif
        m_last = own_d;
        timed  = (lat < 1) || (lat > TO);
        nacc   = timed ? TO : lat;
        for (int c = 0; c <= nacc + 1; c++) begin
            in_acc  = (c >= 1) && (c <= nacc);
            in_resp = (c == nacc + 1);
            iREN = ir; dREN = dr; dWEN = dw;
            iaddr = ia; daddr = da; dstore = ds;
            ramready = !timed && (c == lat);
            ramload  = (c == lat) ? rl : 32'hFFFF_0000;
            if (in_resp) begin
                if (!own_d)   m_iload = timed ? TOD : rl;
                else if (timed) m_dload = TOD;
                else if (!dw) m_dload = rl;
                if (timed) m_err = 1'b1;
            end
            exp_iwait = ir && !(in_resp && !own_d);
            exp_dwait = (dr || dw) && !(in_resp && own_d);
            exp_ren   = in_acc && (own_d ? (dr && !dw) : ir);
            exp_wen   = in_acc && own_d && dw;
            exp_acc   = in_acc;
            exp_addr  = own_d ? da : ia;
            exp_store = ds;
            exp_wrchk = in_acc && own_d && dw;
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 0; chk_en = 0;
        iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
        m_iload = 0; m_dload = 0; m_err = 0; m_last = 0;
        exp_iwait = 0; exp_dwait = 0; exp_ren = 0; exp_wen = 0;
        exp_acc = 0; exp_wrchk = 0; exp_addr = 0; exp_store = 0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1;
        chk("reset_iload", iload, 32'h0);
        chk("reset_err", {31'd0, err}, 32'h0);
        chk_en = 1;

        // ramready while idle must be ignored
        idle(1, 1'b0);
        idle(2, 1'b1);

        access(1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h2408000A, 3);
        chk("lit_iload", iload, 32'h2408000A);

        access(0, 0, 1, 32'h0, 32'h80, 32'hDEADBEEF, 32'h1234_5678, 2);
        chk("lit_dload_after_write", dload, 32'h0);

        access(0, 1, 0, 32'h0, 32'h100, 32'h0, 32'hCAFE_0001, 0);
        chk("lit_dload_timeout", dload, 32'hBAD1BAD1);
        access(1, 0, 0, 32'h44, 32'h0, 32'h0, 32'h1111_2222, 1);
        chk("lit_iload_after_to", iload, 32'h1111_2222);
        chk("lit_err_sticky", {31'd0, err}, 32'h1);

        // ready on the final allowed ACC cycle completes normally
        access(0, 1, 0, 32'h0, 32'h104, 32'h0, 32'h0BAD_F00D, TO);
        chk("lit_dload_edge", dload, 32'h0BAD_F00D);

        // read+write together is a write
        access(0, 1, 1, 32'h0, 32'h84, 32'h5555_AAAA, 32'h9999_9999, 1);

        // contention, last owner is D here
        access(1, 1, 0, 32'h48, 32'h88, 32'h0, 32'hA0A0_A0A0, 2);
`ifdef ARB_RR_EN
        chk("lit_contend_first", iload, 32'hA0A0_A0A0);
`else
        chk("lit_contend_first", dload, 32'hA0A0_A0A0);
`endif
        access(1, 1, 0, 32'h48, 32'h88, 32'h0, 32'hB0B0_B0B0, 1);
        access(1, 1, 0, 32'h48, 32'h88, 32'h0, 32'hC0C0_C0C0, 2);
        access(1, 0, 0, 32'h4C, 32'h0, 32'h0, 32'hD0D0_D0D0, 1);
        idle(1, 1'b0);

        // reset in the middle of a write access
        chk_en = 0;
        dWEN = 1; daddr = 32'h200; dstore = 32'h1357_9BDF; ramready = 0;
        @(posedge CLK); #1;
        chk("rst_pre_wen", {31'd0, ramWEN}, 32'h1);
        #2 nRST = 0;
        #1;
        chk("rst_async_wen", {31'd0, ramWEN}, 32'h0);
        chk("rst_async_ren", {31'd0, ramREN}, 32'h0);
        chk("rst_iload", iload, 32'h0);
        chk("rst_dload", dload, 32'h0);
        chk("rst_err", {31'd0, err}, 32'h0);
        dWEN = 0;
        @(posedge CLK); #1 nRST = 1;
        m_iload = 0; m_dload = 0; m_err = 0; m_last = 0;
        chk_en = 1;

        idle(1, 1'b0);
        access(1, 0, 0, 32'h50, 32'h0, 32'h0, 32'h0F0F_0F0F, 1);
        chk("lit_iload_post_rst", iload, 32'h0F0F_0F0F);
        idle(2, 1'b0);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction fetch port and the data port of the pipelined datapath.
- Each port is a level-sensitive request with a wait-state response.
- Sequences every access through an FSM with a RAM-latency watchdog.
- Sits between the datapath cache interface and the RAM model / bus.

Parameters:
TIMEOUT, 64, max cycles in ACC waiting for ramready before abort (must be >= 2)
TO_DATA, 32'hBAD1BAD1, load value returned on a timed-out access

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
iREN  input  1  instruction read request
iaddr  input  32  instruction byte address
iload  output  32  instruction read data, registered
iwait  output  1  instruction port stall
dREN  input  1  data read request
dWEN  input  1  data write request
daddr  input  32  data byte address
dstore  input  32  data write value
dload  output  32  data read data, registered
dwait  output  1  data port stall
ramREN  output  1  RAM read strobe
ramWEN  output  1  RAM write strobe
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ramready  input  1  RAM completes current access this cycle
err  output  1  sticky timeout flag

Behaviour:
- Clock CLK; reset nRST asynchronous, active-low.
- Reset values: state=IDLE, owner=I, last=I, iload=0, dload=0, err=0, counter=0. RAM strobes go low immediately on reset assertion.
- States:
  - IDLE: pick a requester (arbitration rule below).
    - dREN|dWEN wins over iREN (default fixed priority); record owner and last; go to ACC.
    - No request: stay in IDLE.
  - ACC: drive the RAM from owner's port (ramaddr=iaddr or daddr; ramstore=dstore).
    - ramWEN=dWEN for the D port; ramREN=iREN, or dREN&!dWEN for the D port.
    - Counter increments every cycle.
    - On ramready: capture ramload into iload/dload (reads only); go to RESP.
    - On counter==TIMEOUT-1 without ramready: load TO_DATA into owner's load register, set err, go to RESP.
  - RESP: one cycle; clear counter; go to IDLE. RAM strobes are low.
- Strobes outside ACC: ramREN=ramWEN=0; ramaddr/ramstore hold last driven value.
- Wait outputs (combinational):
  - iwait = iREN & !(state==RESP & owner==I)
  - dwait = (dREN|dWEN) & !(state==RESP & owner==D)
  - The wait signal is low for exactly the RESP cycle of a completed access. A port with no request sees wait=0.
- Latency: request visible in IDLE at cycle 0 → ACC cycles 1..k (ramready at k) → RESP at k+1 → next grant decided at k+2.
- dREN&dWEN together: treated as a write.
- Requester must hold address, data and strobe stable until its wait drops; the arbiter does not latch them.
- Request withdrawn during ACC: the RAM access still completes or times out. Load register is still updated; no stall is reported.
- Write completion: the load register is unchanged.
- ramready in IDLE/RESP: ignored.
- err stays 1 until reset.
- Reset mid-ACC: access is abandoned; no load update.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin. When both ports request in IDLE, grant the port that is not `last`; a single requester is granted regardless.
- Undefined: fixed D-over-I priority; `last` is still tracked but unused.

Test Plan:
- iREN=1, iaddr=0x40; ramready on 3rd ACC cycle with ramload=0x2408000A → iwait low exactly one cycle (RESP), iload=0x2408000A; dwait=0 throughout.
- iREN=1 and dREN=1 held from the same cycle → default build: D served first, then I; ARB_RR_EN with last=D: I first, then D, alternating on sustained contention.
- dWEN=1, daddr=0x80, dstore=0xDEADBEEF → ramWEN=1, ramaddr=0x80, ramstore=0xDEADBEEF during ACC; dload unchanged; dwait drops in RESP.
- TIMEOUT=8, dREN=1, ramready never asserted → after 8 ACC cycles dload=0xBAD1BAD1, err=1 and stays 1; the next I access completes normally.
- nRST pulsed low during ACC → ramREN/ramWEN drop asynchronously; after release state=IDLE, loads=0, err=0.
- dREN=dWEN=1 → write performed, ramREN=0.
